// File: rtl/mult_pkg.sv
// Shared definitions for the sequential shift-and-add multiplier:
// FSM state encoding, default operand width and count-width helper.
package mult_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  localparam int N_DEFAULT = 8;

  // Counter holds 0..N-1, so $clog2(N) bits suffice for every legal N >= 2.
  function automatic int count_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/adder_Nbit.sv
// Combinational N-bit ripple-carry adder built from single-bit full adders.
// The multiplier uses it for one partial-product add per clock.
module Full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);
  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));
endmodule

module adder_Nbit #(
  parameter int N = 8
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         carry_in,
  output logic [N-1:0] sum,
  output logic         carry_out
);
  logic [N:0] c;

  assign c[0]      = carry_in;
  assign carry_out = c[N];

  for (genvar i = 0; i < N; i++) begin : g_bit
    Full_adder u_fa (
      .a   (a[i]),
      .b   (b[i]),
      .cin (c[i]),
      .s   (sum[i]),
      .cout(c[i+1])
    );
  end
endmodule

// File: rtl/seq_multiplier_nbit.sv
// Sequential unsigned shift-and-add multiplier: N add/shift cycles per operation,
// registered 2N-bit product and a one-cycle done strobe.
module seq_multiplier_nbit
  import mult_pkg::*;
#(
  parameter int N = N_DEFAULT
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [N-1:0]   A,
  input  logic [N-1:0]   B,
  output logic           busy,
  output logic           done,
  output logic [2*N-1:0] product,
  output state_t         fsm_state
);
  localparam int CW = count_width(N);

  // Handshake: start is a request sampled only while busy=0 (IDLE or DONE);
  // there is no backpressure, done is a single-cycle strobe and product holds.
  state_t           state, next_state;
  logic [N-1:0]     acc, mq, mcand, sum;
  logic             carry_out;
  logic [CW-1:0]    count;
  logic             accept, last;
  logic [2*N-1:0]   shifted;

  adder_Nbit #(.N(N)) u_add (
    .a        (acc),
    .b        (mcand),
    .carry_in (1'b0),
    .sum      (sum),
    .carry_out(carry_out)
  );

  // The adder carry shifts into acc[N-1], so no product bit is ever dropped.
  assign shifted   = mq[0] ? {carry_out, sum, mq[N-1:1]} : {1'b0, acc, mq[N-1:1]};
  assign last      = (count == CW'(N - 1));
  assign fsm_state = state;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    accept     = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          accept     = 1'b1;
          next_state = RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        if (last) next_state = DONE;
      end
      DONE: begin
        done = 1'b1;
        if (start) begin
          accept     = 1'b1;
          next_state = RUN;
        end else begin
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc     <= '0;
      mq      <= '0;
      mcand   <= '0;
      count   <= '0;
      product <= '0;
    end else if (accept) begin
      mcand <= A;
      mq    <= B;
      acc   <= '0;
      count <= '0;
    end else if (state == RUN) begin
      acc   <= shifted[2*N-1:N];
      mq    <= shifted[N-1:0];
      count <= count + CW'(1);
      if (last) product <= shifted;
    end
  end

endmodule
